// File: rtl/aes_host_sequencer.sv
// ---------------------------------------------------------------------------
// aes_host_sequencer
//
// Drives the aes_core control interface on behalf of a host. A host key or
// block transaction (valid/ready) is turned into a single-cycle start pulse
// towards the core. The sequencer then waits for the matching completion flag
// and hands the captured result back on a valid/ready output channel.
//
// Ports
//   clk, reset_n          : rising-edge clock, asynchronous active-low reset
//   key_valid/ready/data  : host key load channel (key has priority)
//   in_valid/ready/data   : host block channel, in_decrypt selects the mode
//   out_valid/ready/data  : result channel towards the host
//   err_timeout, err_clr  : sticky completion-timeout flag and its clear
//   key_loaded            : a key expansion has finished since reset
//   blk_count             : number of completed blocks (wraps)
//   core_*                : start pulses, registered operands and the
//                           completion flags/results of aes_core
// ---------------------------------------------------------------------------
module aes_host_sequencer #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [127:0]     key_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic             in_decrypt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic             err_timeout,
  input  logic             err_clr,
  output logic             key_loaded,
  output logic [CNT_W-1:0] blk_count,
  output logic             core_reset_key,
  output logic [127:0]     core_key,
  input  logic             core_ready_key,
  output logic             core_reset_enc,
  output logic             core_reset_dec,
  output logic [127:0]     core_block_enc,
  output logic [127:0]     core_block_dec,
  input  logic             core_oready_enc,
  input  logic             core_oready_dec,
  input  logic [127:0]     core_result_enc,
  input  logic [127:0]     core_result_dec
);

  typedef enum logic [2:0] {NOKEY, KEXP, IDLE, RUN, OUT} state_e;

  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [127:0]       core_key_q, core_key_d;
  logic [127:0]       blk_enc_q, blk_enc_d;
  logic [127:0]       blk_dec_q, blk_dec_d;
  logic [127:0]       out_data_q, out_data_d;
  logic               mode_q, mode_d;
  logic               out_valid_q, out_valid_d;
  logic               err_q, err_d;
  logic               key_loaded_q, key_loaded_d;
  logic               pulse_key_q, pulse_key_d;
  logic               pulse_enc_q, pulse_enc_d;
  logic               pulse_dec_q, pulse_dec_d;
  logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;
  logic [9:0]         tmo_q, tmo_d;

  logic guard_done;
  logic tmo_hit;
  logic run_done;

  // The counter is cleared on acceptance, so it reads 0 in the pulse cycle
  // and 1 in the cycle after; completion flags seen then may be stale.
  assign guard_done = (tmo_q >= 10'd2);
  assign tmo_hit    = (tmo_q == TMO_LAST);
  assign run_done   = mode_q ? core_oready_dec : core_oready_enc;

  assign key_ready = (state_q == NOKEY) || (state_q == IDLE);
  assign in_ready  = (state_q == IDLE) && !key_valid;

  always_comb begin
    state_d      = state_q;
    core_key_d   = core_key_q;
    blk_enc_d    = blk_enc_q;
    blk_dec_d    = blk_dec_q;
    out_data_d   = out_data_q;
    mode_d       = mode_q;
    out_valid_d  = out_valid_q;
    err_d        = err_q;
    key_loaded_d = key_loaded_q;
    pulse_key_d  = 1'b0;
    pulse_enc_d  = 1'b0;
    pulse_dec_d  = 1'b0;
    blk_cnt_d    = blk_cnt_q;
    tmo_d        = tmo_q;

    // A timeout raised below overrides this clear.
    if (err_clr) begin
      err_d = 1'b0;
    end

    case (state_q)
      NOKEY, IDLE: begin
        if (key_valid) begin
          core_key_d  = key_data;
          pulse_key_d = 1'b1;
          tmo_d       = '0;
          state_d     = KEXP;
        end else if (in_valid && (state_q == IDLE)) begin
          if (in_decrypt) begin
            blk_dec_d   = in_data;
            pulse_dec_d = 1'b1;
          end else begin
            blk_enc_d   = in_data;
            pulse_enc_d = 1'b1;
          end
          mode_d  = in_decrypt;
          tmo_d   = '0;
          state_d = RUN;
        end
      end

      KEXP: begin
        tmo_d = tmo_q + 10'd1;
        if (guard_done && core_ready_key) begin
          key_loaded_d = 1'b1;
          state_d      = IDLE;
        end else if (tmo_hit) begin
          err_d        = 1'b1;
          key_loaded_d = 1'b0;
          state_d      = NOKEY;
        end
      end

      RUN: begin
        tmo_d = tmo_q + 10'd1;
        if (guard_done && run_done) begin
          out_data_d  = mode_q ? core_result_dec : core_result_enc;
          out_valid_d = 1'b1;
          blk_cnt_d   = blk_cnt_q + CNT_W'(1);
          state_d     = OUT;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = NOKEY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= NOKEY;
      core_key_q   <= '0;
      blk_enc_q    <= '0;
      blk_dec_q    <= '0;
      out_data_q   <= '0;
      mode_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      key_loaded_q <= 1'b0;
      pulse_key_q  <= 1'b0;
      pulse_enc_q  <= 1'b0;
      pulse_dec_q  <= 1'b0;
      blk_cnt_q    <= '0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      core_key_q   <= core_key_d;
      blk_enc_q    <= blk_enc_d;
      blk_dec_q    <= blk_dec_d;
      out_data_q   <= out_data_d;
      mode_q       <= mode_d;
      out_valid_q  <= out_valid_d;
      err_q        <= err_d;
      key_loaded_q <= key_loaded_d;
      pulse_key_q  <= pulse_key_d;
      pulse_enc_q  <= pulse_enc_d;
      pulse_dec_q  <= pulse_dec_d;
      blk_cnt_q    <= blk_cnt_d;
      tmo_q        <= tmo_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign err_timeout    = err_q;
  assign key_loaded     = key_loaded_q;
  assign blk_count      = blk_cnt_q;
  assign core_reset_key = pulse_key_q;
  assign core_key       = core_key_q;
  assign core_reset_enc = pulse_enc_q;
  assign core_reset_dec = pulse_dec_q;
  assign core_block_enc = blk_enc_q;
  assign core_block_dec = blk_dec_q;

endmodule

// File: tb/tb_aes_host_sequencer.sv
// ---------------------------------------------------------------------------
// tb_aes_host_sequencer
//
// Bench for aes_host_sequencer with a behavioural aes_core stand-in. Results
// expected for every accepted block are queued at acceptance and compared
// when the sequencer hands a result back to the host.
// ---------------------------------------------------------------------------
module tb_aes_host_sequencer;

  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 16;

  localparam logic [127:0] K1 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] K2 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] PT = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
  localparam logic [127:0] X1 = 128'hdeadbeef_01234567_89abcdef_cafef00d;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             key_valid;
  logic             key_ready;
  logic [127:0]     key_data;
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_data;
  logic             in_decrypt;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_data;
  logic             err_timeout;
  logic             err_clr;
  logic             key_loaded;
  logic [CNT_W-1:0] blk_count;
  logic             core_reset_key;
  logic [127:0]     core_key;
  logic             core_ready_key = 1'b0;
  logic             core_reset_enc;
  logic             core_reset_dec;
  logic [127:0]     core_block_enc;
  logic [127:0]     core_block_dec;
  logic             core_oready_enc = 1'b0;
  logic             core_oready_dec = 1'b0;
  logic [127:0]     core_result_enc = '0;
  logic [127:0]     core_result_dec = '0;

  int checks = 0;
  int errors = 0;
  int keyPulses = 0;
  int encPulses = 0;
  int decPulses = 0;
  int multiPulse = 0;
  int doneCount = 0;
  bit hangKey = 1'b0;
  bit hangEnc = 1'b0;
  logic [127:0] curKey = '0;
  logic [127:0] expQ[$];

  aes_host_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .key_valid(key_valid), .key_ready(key_ready), .key_data(key_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_decrypt(in_decrypt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err_timeout(err_timeout), .err_clr(err_clr),
    .key_loaded(key_loaded), .blk_count(blk_count),
    .core_reset_key(core_reset_key), .core_key(core_key),
    .core_ready_key(core_ready_key),
    .core_reset_enc(core_reset_enc), .core_reset_dec(core_reset_dec),
    .core_block_enc(core_block_enc), .core_block_dec(core_block_dec),
    .core_oready_enc(core_oready_enc), .core_oready_dec(core_oready_dec),
    .core_result_enc(core_result_enc), .core_result_dec(core_result_dec)
  );

  always #5 clk = ~clk;

  // Stand-in for aes_core: the known-answer vector for K1, otherwise an
  // easily predicted mix of block, key and mode.
  function automatic logic [127:0] coreFunc(input logic [127:0] blk,
                                            input logic [127:0] key,
                                            input logic dec);
    if (!dec && blk == PT && key == K1) return CT;
    if (dec && blk == CT && key == K1) return PT;
    return blk ^ key ^ (dec ? {4{32'h5a5a5a5a}} : {4{32'hc3c3c3c3}});
  endfunction

  // Completion flags are levels: dropped by the start pulse, raised after a
  // fixed latency, so a stale flag is still high during the pulse cycle.
  int keyCnt = 0;
  int encCnt = 0;
  int decCnt = 0;
  logic [127:0] encBlk = '0;
  logic [127:0] decBlk = '0;

  always @(posedge clk) begin
    if (core_reset_key) begin
      core_ready_key <= 1'b0;
      keyCnt         <= hangKey ? 0 : 3;
    end else if (keyCnt > 0) begin
      keyCnt <= keyCnt - 1;
      if (keyCnt == 1) core_ready_key <= 1'b1;
    end
    if (core_reset_enc) begin
      core_oready_enc <= 1'b0;
      encBlk          <= core_block_enc;
      encCnt          <= hangEnc ? 0 : 4;
    end else if (encCnt > 0) begin
      encCnt <= encCnt - 1;
      if (encCnt == 1) begin
        core_oready_enc <= 1'b1;
        core_result_enc <= coreFunc(encBlk, core_key, 1'b0);
      end
    end
    if (core_reset_dec) begin
      core_oready_dec <= 1'b0;
      decBlk          <= core_block_dec;
      decCnt          <= 3;
    end else if (decCnt > 0) begin
      decCnt <= decCnt - 1;
      if (decCnt == 1) begin
        core_oready_dec <= 1'b1;
        core_result_dec <= coreFunc(decBlk, core_key, 1'b1);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] act,
                             input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  // Scoreboard and pulse monitor, sampled 1 time unit after the falling
  // edge, after the drivers have updated their inputs for the cycle.
  always begin
    @(negedge clk);
    #1;
    if (core_reset_key) keyPulses++;
    if (core_reset_enc) encPulses++;
    if (core_reset_dec) decPulses++;
    if (int'(core_reset_key) + int'(core_reset_enc) + int'(core_reset_dec) > 1)
      multiPulse++;
    if (reset_n && in_valid && in_ready && !(hangEnc && !in_decrypt))
      expQ.push_back(coreFunc(in_data, curKey, in_decrypt));
    if (reset_n && out_valid && out_ready) begin
      checkOutput("sb_nonempty", 128'(expQ.size() > 0), 128'd1);
      if (expQ.size() > 0) begin
        checkOutput("out_data", out_data, expQ.pop_front());
        doneCount++;
        checkOutput("blk_count", 128'(blk_count), 128'(doneCount % (1 << CNT_W)));
      end
    end
  end

  task automatic checkResetValues();
    checkOutput("rst_out_valid", 128'(out_valid), 128'd0);
    checkOutput("rst_out_data", out_data, 128'd0);
    checkOutput("rst_core_key", core_key, 128'd0);
    checkOutput("rst_blk_enc", core_block_enc, 128'd0);
    checkOutput("rst_blk_dec", core_block_dec, 128'd0);
    checkOutput("rst_blk_count", 128'(blk_count), 128'd0);
    checkOutput("rst_err", 128'(err_timeout), 128'd0);
    checkOutput("rst_key_loaded", 128'(key_loaded), 128'd0);
    checkOutput("rst_pulses",
                128'({core_reset_key, core_reset_enc, core_reset_dec}), 128'd0);
    checkOutput("rst_key_ready", 128'(key_ready), 128'd1);
    checkOutput("rst_in_ready", 128'(in_ready), 128'd0);
  endtask

  // Offers a key and follows it through expansion (or its timeout).
  task automatic loadKey(input logic [127:0] k);
    int n;
    int p0;
    bit sawInReady;
    @(negedge clk);
    key_valid = 1'b1;
    key_data  = k;
    #2;
    n = 0;
    while (!key_ready && n < 50) begin
      @(negedge clk); #2; n++;
    end
    checkOutput("key_accept", 128'(key_ready), 128'd1);
    curKey = k;
    p0 = keyPulses;
    @(negedge clk);
    key_valid = 1'b0;
    #2;
    checkOutput("key_pulse", 128'(core_reset_key), 128'd1);
    checkOutput("core_key", core_key, k);
    n = 0;
    sawInReady = 1'b0;
    while (!key_ready && n < 50) begin
      sawInReady |= in_ready;
      @(negedge clk); #2; n++;
    end
    checkOutput("kexp_done", 128'(key_ready), 128'd1);
    checkOutput("kexp_in_ready", 128'(sawInReady), 128'd0);
    checkOutput("key_loaded", 128'(key_loaded), 128'(!hangKey));
    checkOutput("key_pulse_count", 128'(keyPulses - p0), 128'd1);
  endtask

  // Offers one block and checks the start pulse and the registered operand.
  task automatic applyStimulus(input logic [127:0] data, input logic dec);
    int n;
    @(negedge clk);
    in_valid   = 1'b1;
    in_data    = data;
    in_decrypt = dec;
    #2;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk); #2; n++;
    end
    checkOutput("in_accept", 128'(in_ready), 128'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    checkOutput(dec ? "dec_pulse" : "enc_pulse",
                128'(dec ? core_reset_dec : core_reset_enc), 128'd1);
    checkOutput("core_block", dec ? core_block_dec : core_block_enc, data);
  endtask

  task automatic waitDone(input int target);
    int n;
    n = 0;
    while (doneCount < target && n < 100) begin
      @(negedge clk); #2; n++;
    end
    checkOutput("wait_done", 128'(doneCount >= target), 128'd1);
  endtask

  // Runs a block the core never completes and measures the timeout latency.
  task automatic hungBlock();
    int n;
    int c0;
    c0 = doneCount;
    hangEnc = 1'b1;
    applyStimulus(PT, 1'b0);
    n = 0;
    while (!err_timeout && n < 30) begin
      @(negedge clk); #2; n++;
    end
    checkOutput("tmo_cycles", 128'(n), 128'(TIMEOUT));
    checkOutput("tmo_out_valid", 128'(out_valid), 128'd0);
    checkOutput("tmo_in_ready", 128'(in_ready), 128'd1);
    checkOutput("tmo_blk_count", 128'(blk_count), 128'(c0));
    hangEnc = 1'b0;
  endtask

  initial begin
    int e0;
    int d0;
    int k0;
    int n;
    reset_n    = 1'b0;
    key_valid  = 1'b0;
    key_data   = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_decrypt = 1'b0;
    out_ready  = 1'b1;
    err_clr    = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    checkResetValues();
    @(negedge clk);
    reset_n = 1'b1;

    // Key load and known-answer encrypt / decrypt.
    loadKey(K1);
    e0 = encPulses; d0 = decPulses;
    applyStimulus(PT, 1'b0);
    waitDone(1);
    checkOutput("enc_pulses", 128'(encPulses - e0), 128'd1);
    checkOutput("enc_no_dec", 128'(decPulses - d0), 128'd0);
    e0 = encPulses; d0 = decPulses;
    applyStimulus(CT, 1'b1);
    waitDone(2);
    checkOutput("dec_pulses", 128'(decPulses - d0), 128'd1);
    checkOutput("dec_no_enc", 128'(encPulses - e0), 128'd0);

    // Output back-pressure with the next block already offered.
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(PT, 1'b0);
    n = 0;
    while (!out_valid && n < 30) begin
      @(negedge clk); #2; n++;
    end
    checkOutput("stall_seen", 128'(out_valid), 128'd1);
    @(negedge clk);
    in_valid   = 1'b1;
    in_data    = CT;
    in_decrypt = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #2;
      checkOutput("stall_valid", 128'(out_valid), 128'd1);
      checkOutput("stall_data", out_data, CT);
      checkOutput("stall_in_ready", 128'(in_ready), 128'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #2;
    checkOutput("hs_in_ready", 128'(in_ready), 128'd0);
    n = 0;
    while (!in_ready && n < 10) begin
      @(negedge clk); #2; n++;
    end
    checkOutput("next_accept", 128'(in_ready), 128'd1);
    @(negedge clk);
    in_valid = 1'b0;
    waitDone(4);

    // Key and block offered together: the key wins.
    k0 = keyPulses;
    @(negedge clk);
    key_valid  = 1'b1;
    key_data   = K2;
    in_valid   = 1'b1;
    in_data    = X1;
    in_decrypt = 1'b0;
    #2;
    checkOutput("prio_in_ready", 128'(in_ready), 128'd0);
    checkOutput("prio_key_ready", 128'(key_ready), 128'd1);
    curKey = K2;
    @(negedge clk);
    key_valid = 1'b0;
    #2;
    checkOutput("prio_key_pulse", 128'(core_reset_key), 128'd1);
    checkOutput("prio_core_key", core_key, K2);
    n = 0;
    while (!in_ready && n < 30) begin
      @(negedge clk); #2; n++;
    end
    checkOutput("prio_blk_accept", 128'(in_ready), 128'd1);
    @(negedge clk);
    in_valid = 1'b0;
    waitDone(5);
    checkOutput("prio_key_pulses", 128'(keyPulses - k0), 128'd1);

    // Block timeout, then clear.
    hungBlock();
    @(negedge clk);
    err_clr = 1'b1;
    #2;
    checkOutput("err_sticky", 128'(err_timeout), 128'd1);
    @(negedge clk);
    err_clr = 1'b0;
    #2;
    checkOutput("err_cleared", 128'(err_timeout), 128'd0);

    // Timeout coinciding with a held clear: the set wins for one cycle.
    @(negedge clk);
    err_clr = 1'b1;
    hungBlock();
    @(negedge clk);
    #2;
    checkOutput("err_clr_after", 128'(err_timeout), 128'd0);
    err_clr = 1'b0;

    // Key expansion timeout drops back to NOKEY.
    hangKey = 1'b1;
    loadKey(K1);
    hangKey = 1'b0;
    checkOutput("kexp_tmo_err", 128'(err_timeout), 128'd1);
    checkOutput("kexp_tmo_in_ready", 128'(in_ready), 128'd0);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    loadKey(K1);
    applyStimulus(PT, 1'b0);
    waitDone(6);

    // Reset in the middle of a block.
    hangEnc = 1'b1;
    applyStimulus(PT, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #2;
    checkResetValues();
    hangEnc = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    doneCount = 0;
    k0 = keyPulses + encPulses + decPulses;
    repeat (10) @(negedge clk);
    #2;
    checkOutput("post_rst_pulses", 128'(keyPulses + encPulses + decPulses - k0), 128'd0);
    checkOutput("post_rst_key_ready", 128'(key_ready), 128'd1);
    checkOutput("post_rst_in_ready", 128'(in_ready), 128'd0);
    checkOutput("post_rst_out_valid", 128'(out_valid), 128'd0);

    checkOutput("pulse_onehot", 128'(multiPulse), 128'd0);
    checkOutput("sb_drained", 128'(expQ.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule
